// File: rtl/isp_pkg.sv
// isp_pkg -- shared ISP definitions for the YUV tone-curve stage.
//   DATA_W_DEF / SEG_BITS_DEF : default component width and segment-index width
//   knot_count()              : number of knots for a given SEG_BITS (2^SEG_BITS+1)
//   identity_knot()           : reset value of knot idx, min(idx<<FRAC_W, 2^DATA_W-1)
package isp_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int SEG_BITS_DEF = 5;

  function automatic int knot_count(input int seg_bits);
    return (1 << seg_bits) + 1;
  endfunction

  // The last knot sits one full segment past the top code, so it saturates.
  function automatic int identity_knot(input int idx, input int data_w, input int frac_w);
    int v;
    v = idx << frac_w;
    if (v > (1 << data_w) - 1) v = (1 << data_w) - 1;
    return v;
  endfunction

endpackage

// File: rtl/tone_interp_pipe.sv
// tone_interp_pipe -- three-stage knot interpolation for the luma tone curve.
//   clk, rst : pixel clock, synchronous active-high reset
//   k0_i     : knot at the segment floor
//   k1_i     : knot at the segment ceiling
//   f_i      : position inside the segment (Y LSBs)
//   y_o      : mapped luma, 3 cycles after k0_i/k1_i/f_i
// TONE_INTERP_EN defined : y = clamp(k0 + round_floor((k1-k0)*f / 2^FRAC_W))
// TONE_INTERP_EN undefined: y = k0 (k1_i and f_i are ignored), same latency.
module tone_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] k0_i,
  input  logic [DATA_W-1:0] k1_i,
  input  logic [FRAC_W-1:0] f_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] k0_s1_q, k0_s2_q, y_q;

`ifdef TONE_INTERP_EN
  // |d| < 2^DATA_W and f < 2^FRAC_W, so the product fits PW signed bits.
  localparam int PW = DATA_W + FRAC_W + 2;
  localparam logic signed [PW:0] RND  = (PW+1)'(1 << (FRAC_W-1));
  localparam logic signed [PW:0] YMAX = (PW+1)'((1 << DATA_W) - 1);

  logic [DATA_W-1:0]    k1_s1_q;
  logic [FRAC_W-1:0]    f_s1_q;
  logic signed [PW-1:0] d_ext, f_ext, p_d, p_q;
  logic signed [PW:0]   t_d, sum_d;
  logic [DATA_W-1:0]    y_d;

  always_comb begin
    d_ext = PW'($signed({1'b0, k1_s1_q}) - $signed({1'b0, k0_s1_q}));
    f_ext = PW'(f_s1_q);
    p_d   = d_ext * f_ext;
    // Round-half-up then arithmetic shift: negative slopes floor toward -inf.
    t_d   = $signed({p_q[PW-1], p_q}) + RND;
    sum_d = (t_d >>> FRAC_W) + $signed({{(PW+1-DATA_W){1'b0}}, k0_s2_q});
    if (sum_d[PW])          y_d = '0;
    else if (sum_d > YMAX)  y_d = '1;
    else                    y_d = sum_d[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k0_s1_q <= '0;
      k1_s1_q <= '0;
      f_s1_q  <= '0;
      p_q     <= '0;
      k0_s2_q <= '0;
      y_q     <= '0;
    end else begin
      k0_s1_q <= k0_i;
      k1_s1_q <= k1_i;
      f_s1_q  <= f_i;
      p_q     <= p_d;
      k0_s2_q <= k0_s1_q;
      y_q     <= y_d;
    end
  end
`else
  logic unused_interp;
  assign unused_interp = ^{k1_i, f_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      k0_s1_q <= '0;
      k0_s2_q <= '0;
      y_q     <= '0;
    end else begin
      k0_s1_q <= k0_i;
      k0_s2_q <= k0_s1_q;
      y_q     <= k0_s2_q;
    end
  end
`endif

  assign y_o = y_q;

endmodule

// File: rtl/yuv_tone_curve.sv
// yuv_tone_curve -- programmable piecewise-linear luma tone curve, 3-cycle latency.
//   clk, rst        : pixel clock, synchronous active-high reset
//   Pre_YUV/_en     : input pixel {Y,U,V} and valid
//   Pre_vsync       : frame sync; its rising edge is the frame boundary
//   Post_YUV/_en    : output pixel {Y',U,V} and valid
//   Post_vsync      : Pre_vsync delayed to match the data
//   lut_wr_en/addr/data : shadow knot write (addresses above 2^SEG_BITS ignored)
//   lut_commit      : request to copy shadow into active at the next frame edge
//   lut_pending     : commit accepted, swap not yet done
// Build option: TONE_INTERP_EN enables linear interpolation between knots;
// without it Y' is the segment-floor knot.
module yuv_tone_curve import isp_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEG_BITS = SEG_BITS_DEF,
  parameter int FRAC_W   = DATA_W - SEG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*DATA_W-1:0]   Pre_YUV,
  input  logic                  Pre_YUV_en,
  input  logic                  Pre_vsync,
  output logic [3*DATA_W-1:0]   Post_YUV,
  output logic                  Post_YUV_en,
  output logic                  Post_vsync,
  input  logic                  lut_wr_en,
  input  logic [SEG_BITS:0]     lut_wr_addr,
  input  logic [DATA_W-1:0]     lut_wr_data,
  input  logic                  lut_commit,
  output logic                  lut_pending
);

  localparam int KNOTS  = knot_count(SEG_BITS);
  localparam int AW     = SEG_BITS + 1;
  localparam int STAGES = 3;

  logic [DATA_W-1:0]   shadow_q [KNOTS];
  logic [DATA_W-1:0]   active_q [KNOTS];
  logic                vsync_q, pending_q, pending_d;
  logic                rise, swap, wr_ok;

  assign rise  = Pre_vsync & ~vsync_q;
  assign swap  = rise & pending_q;
  assign wr_ok = lut_wr_en && (lut_wr_addr <= AW'(KNOTS-1));

  // A swap consumes the pending request even if a commit arrives with it.
  always_comb begin
    pending_d = pending_q;
    if (swap)            pending_d = 1'b0;
    else if (lut_commit) pending_d = 1'b1;
  end

  // The swap copies the pre-write shadow: both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < KNOTS; k++) begin
        shadow_q[k] <= DATA_W'(identity_knot(k, DATA_W, FRAC_W));
        active_q[k] <= DATA_W'(identity_knot(k, DATA_W, FRAC_W));
      end
      vsync_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (swap)  active_q <= shadow_q;
      if (wr_ok) shadow_q[lut_wr_addr] <= lut_wr_data;
      vsync_q   <= Pre_vsync;
      pending_q <= pending_d;
    end
  end

  // Knot lookup reads the current active table, so a pixel sampled with the
  // frame edge still sees the old curve.
  logic [SEG_BITS-1:0] seg;
  logic [FRAC_W-1:0]   frac;
  logic [DATA_W-1:0]   k0, k1, y_out;

  assign seg  = Pre_YUV[3*DATA_W-1 -: SEG_BITS];
  assign frac = Pre_YUV[2*DATA_W+FRAC_W-1 -: FRAC_W];
  assign k0   = active_q[{1'b0, seg}];
  assign k1   = active_q[AW'(seg) + AW'(1)];

  tone_interp_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_interp (
    .clk  (clk),
    .rst  (rst),
    .k0_i (k0),
    .k1_i (k1),
    .f_i  (frac),
    .y_o  (y_out)
  );

  // Side-band delay lines matching the interpolation pipe.
  logic [2*DATA_W-1:0] uv_pipe_q [STAGES];
  logic [STAGES-1:0]   en_pipe_q, vs_pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) uv_pipe_q[s] <= '0;
      en_pipe_q <= '0;
      vs_pipe_q <= '0;
    end else begin
      uv_pipe_q[0] <= Pre_YUV[2*DATA_W-1:0];
      for (int s = 1; s < STAGES; s++) uv_pipe_q[s] <= uv_pipe_q[s-1];
      en_pipe_q <= {en_pipe_q[STAGES-2:0], Pre_YUV_en};
      vs_pipe_q <= {vs_pipe_q[STAGES-2:0], Pre_vsync};
    end
  end

  assign Post_YUV    = {y_out, uv_pipe_q[STAGES-1]};
  assign Post_YUV_en = en_pipe_q[STAGES-1];
  assign Post_vsync  = vs_pipe_q[STAGES-1];
  assign lut_pending = pending_q;

endmodule

// File: tb/tb_yuv_tone_curve.sv
module tb_yuv_tone_curve;

  localparam int DW = 8;
  localparam int SB = 5;
  localparam int FW = DW - SB;
  localparam int NK = (1 << SB) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3*DW-1:0] Pre_YUV = '0;
  logic            Pre_YUV_en = 1'b0;
  logic            Pre_vsync = 1'b0;
  logic [3*DW-1:0] Post_YUV;
  logic            Post_YUV_en, Post_vsync;
  logic            lut_wr_en = 1'b0;
  logic [SB:0]     lut_wr_addr = '0;
  logic [DW-1:0]   lut_wr_data = '0;
  logic            lut_commit = 1'b0;
  logic            lut_pending;

  always #5 clk = ~clk;

  yuv_tone_curve #(.DATA_W(DW), .SEG_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .Pre_YUV(Pre_YUV), .Pre_YUV_en(Pre_YUV_en), .Pre_vsync(Pre_vsync),
    .Post_YUV(Post_YUV), .Post_YUV_en(Post_YUV_en), .Post_vsync(Post_vsync),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .lut_commit(lut_commit), .lut_pending(lut_pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: two knot arrays, a pending flag and a 3-deep output queue.
  int          sh [NK];
  int          ac [NK];
  bit          m_pend, m_vsq;
  logic [7:0]  ey  [3];
  logic [15:0] euv [3];
  bit          een [3], evs [3];

  function automatic int ident(int i);
    return ((i << FW) > 255) ? 255 : (i << FW);
  endfunction

  function automatic int curve(int y);
    int t;
`ifdef TONE_INTERP_EN
    int i, f, k0, k1;
    i = y >> FW; f = y % (1 << FW); k0 = ac[i]; k1 = ac[i+1];
    t = k0 + (((k1 - k0) * f + (1 << (FW-1))) >>> FW);
`else
    t = ac[y >> FW];
`endif
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (rst) begin
      for (int k = 0; k < NK; k++) begin sh[k] = ident(k); ac[k] = ident(k); end
      m_pend = 0; m_vsq = 0;
      for (int s = 0; s < 3; s++) begin ey[s] = 0; euv[s] = 0; een[s] = 0; evs[s] = 0; end
    end else begin
      for (int s = 2; s > 0; s--) begin
        ey[s] = ey[s-1]; euv[s] = euv[s-1]; een[s] = een[s-1]; evs[s] = evs[s-1];
      end
      ey[0]  = 8'(curve(int'(Pre_YUV[23:16])));
      euv[0] = Pre_YUV[15:0];
      een[0] = Pre_YUV_en;
      evs[0] = Pre_vsync;
      rise = Pre_vsync && !m_vsq;
      if (rise && m_pend) begin
        for (int k = 0; k < NK; k++) ac[k] = sh[k];
        m_pend = 0;
      end else if (lut_commit) m_pend = 1;
      if (lut_wr_en && lut_wr_addr <= 32) sh[lut_wr_addr] = int'(lut_wr_data);
      m_vsq = Pre_vsync;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_ctl", {29'd0, Post_YUV_en, Post_vsync, lut_pending}, {29'd0, een[2], evs[2], m_pend});
    if (een[2]) check("model_yuv", {8'd0, Post_YUV}, {8'd0, ey[2], euv[2]});
  endtask

  task automatic pix(string nm, logic [7:0] y, logic [7:0] exp_y);
    logic [15:0] uv;
    uv = 16'($urandom);
    Pre_YUV = {y, uv}; Pre_YUV_en = 1'b1; tick();
    Pre_YUV_en = 1'b0; tick();
    check({nm, "_early"}, {31'd0, Post_YUV_en}, 32'd0);
    tick();
    check({nm, "_en"}, {31'd0, Post_YUV_en}, 32'd1);
    check({nm, "_y"},  {24'd0, Post_YUV[23:16]}, {24'd0, exp_y});
    check({nm, "_uv"}, {16'd0, Post_YUV[15:0]}, {16'd0, uv});
  endtask

  task automatic wr(int a, logic [7:0] d);
    lut_wr_en = 1'b1; lut_wr_addr = 6'(a); lut_wr_data = d; tick(); lut_wr_en = 1'b0;
  endtask

  task automatic commit();
    lut_commit = 1'b1; tick(); lut_commit = 1'b0;
  endtask

  task automatic vs_rise();
    Pre_vsync = 1'b1; tick(); Pre_vsync = 1'b0; tick();
  endtask

  typedef struct { string nm; logic [7:0] y; logic [7:0] exp_y; } vec_t;
  vec_t vecs [5];

  // Expected values per build, derived by hand from the curve rules.
`ifdef TONE_INTERP_EN
  localparam logic [7:0] E_FF = 8'hFE, E_13 = 8'h13, E_47 = 8'h47;
  localparam logic [7:0] E_T2_OLD = 8'h14, E_T2 = 8'h30;
  localparam logic [7:0] E_T3_OLD = 8'h2C, E_T3 = 8'h34, E_T4 = 8'h56, E_T5 = 8'hDF;
`else
  localparam logic [7:0] E_FF = 8'hF8, E_13 = 8'h10, E_47 = 8'h40;
  localparam logic [7:0] E_T2_OLD = 8'h10, E_T2 = 8'h20;
  localparam logic [7:0] E_T3_OLD = 8'h20, E_T3 = 8'h40, E_T4 = 8'h77, E_T5 = 8'h00;
`endif

  initial begin
    logic [15:0] uv;
    vecs[0] = '{"id_00", 8'h00, 8'h00};
    vecs[1] = '{"id_80", 8'h80, 8'h80};
    vecs[2] = '{"id_ff", 8'hFF, E_FF};
    vecs[3] = '{"id_13", 8'h13, E_13};
    vecs[4] = '{"id_47", 8'h47, E_47};

    // Reset state
    repeat (3) tick();
    check("rst_out", {5'd0, Post_YUV, Post_YUV_en, Post_vsync, lut_pending}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[n]) pix(vecs[n].nm, vecs[n].y, vecs[n].exp_y);

    // Interpolation after a committed swap
    wr(2, 8'h20); wr(3, 8'h40); commit();
    check("t2_pend", {31'd0, lut_pending}, 32'd1);
    pix("t2_old", 8'h14, E_T2_OLD);
    vs_rise();
    check("t2_pend_clr", {31'd0, lut_pending}, 32'd0);
    pix("t2_new", 8'h14, E_T2);

    // Descending segment, deferred swap, same-cycle write and pixel at the edge
    wr(2, 8'h40); wr(3, 8'h20); commit();
    pix("t3_old", 8'h13, E_T3_OLD);
    uv = 16'($urandom);
    Pre_vsync = 1'b1; lut_wr_en = 1'b1; lut_wr_addr = 6'd2; lut_wr_data = 8'h77;
    Pre_YUV = {8'h13, uv}; Pre_YUV_en = 1'b1;
    tick();
    Pre_vsync = 1'b0; lut_wr_en = 1'b0; Pre_YUV_en = 1'b0;
    check("t4_pend_after_rise", {31'd0, lut_pending}, 32'd0);
    tick(); tick();
    check("t4_edge_pix_old", {8'd0, Post_YUV}, {8'd0, E_T3_OLD, uv});
    pix("t3_new", 8'h13, E_T3);
    commit(); vs_rise();
    pix("t4_wr_shadow", 8'h13, E_T4);

    // Commit in the same cycle as a rise with nothing pending
    wr(10, 8'h99);
    Pre_vsync = 1'b1; lut_commit = 1'b1; tick();
    Pre_vsync = 1'b0; lut_commit = 1'b0; tick();
    check("edge_commit_pend", {31'd0, lut_pending}, 32'd1);
    pix("edge_commit_old", 8'h50, 8'h50);
    vs_rise();
    pix("edge_commit_new", 8'h50, 8'h99);

    // Clamp/range and an out-of-range write
    wr(32, 8'hFF); wr(31, 8'h00); wr(33, 8'h12); commit(); vs_rise();
    pix("t5_top", 8'hFF, E_T5);
    pix("t5_addr33", 8'h08, 8'h08);

    // Reset mid-frame with a pending commit and a valid stream
    wr(5, 8'hAA); commit();
    Pre_YUV_en = 1'b1;
    for (int n = 0; n < 4; n++) begin Pre_YUV = 24'($urandom); tick(); end
    rst = 1'b1; tick();
    check("t6_rst_out", {5'd0, Post_YUV, Post_YUV_en, Post_vsync, lut_pending}, 32'd0);
    Pre_YUV_en = 1'b0; rst = 1'b0; tick();
    pix("t6_ident", 8'h28, 8'h28);
    vs_rise();
    pix("t6_no_swap", 8'h28, 8'h28);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Pre_YUV     = 24'($urandom);
      Pre_YUV_en  = ($urandom_range(0, 3) != 0);
      lut_wr_en   = ($urandom_range(0, 7) == 0);
      lut_wr_addr = 6'($urandom_range(0, 34));
      lut_wr_data = 8'($urandom);
      lut_commit  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) Pre_vsync = ~Pre_vsync;
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; lut_wr_en = 1'b0; lut_commit = 1'b0; Pre_YUV_en = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
